// File: rtl/gpio_host_sequencer_if.sv
// Stream/GPIO bundle between the host sequencer and its environment:
// pixel stream in, result stream out, GPIO control/return words.
interface gpio_host_sequencer_if #(
    parameter int GPIO_D    = 32,
    parameter int RAM_WIDTH = 13,
    parameter int BIT_LEN   = 8
);
    logic [3*BIT_LEN-1:0] i_pix_data;
    logic                 i_pix_valid;
    logic                 o_pix_ready;
    logic [GPIO_D-1:0]    o_gpio_data;
    logic [GPIO_D-1:0]    i_gpio_data;
    logic                 i_eop;
    logic [RAM_WIDTH-1:0] o_res_data;
    logic                 o_res_valid;
    logic                 i_res_ready;
    logic                 o_res_last;

    modport master (
        input  i_pix_data,
        input  i_pix_valid,
        output o_pix_ready,
        output o_gpio_data,
        input  i_gpio_data,
        input  i_eop,
        output o_res_data,
        output o_res_valid,
        input  i_res_ready,
        output o_res_last
    );

    modport slave (
        output i_pix_data,
        output i_pix_valid,
        input  o_pix_ready,
        input  o_gpio_data,
        output i_gpio_data,
        output i_eop,
        input  o_res_data,
        input  o_res_valid,
        output i_res_ready,
        input  o_res_last
    );
endinterface

// File: rtl/gpio_host_sequencer.sv
// GPIO host for the convolution top: load pixels, run, read mem0 results.
// Optional GPIO_SEQ_CHECKSUM_EN appends a modulo checksum beat.
module gpio_host_sequencer #(
    parameter int GPIO_D      = 32,
    parameter int RAM_WIDTH   = 13,
    parameter int BIT_LEN     = 8,
    parameter int NB_IMAGE    = 10,
    parameter int RD_LAT      = 2,
    parameter int RUN_TIMEOUT = 4096
) (
    input  logic                CLK100MHZ,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_IMAGE-1:0] i_img_len,
    gpio_host_sequencer_if.master bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    localparam int RCW = $clog2(RUN_TIMEOUT + 1);
    localparam int LCW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
    localparam int PW  = 3 * BIT_LEN;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT0, S_INIT1, S_WAIT,
        S_W0, S_W1, S_W2, S_RUN,
        S_RREQ, S_RLAT, S_ROUT, S_CSUM
    } state_e;

    state_e               state_q, state_d;
    logic [NB_IMAGE-1:0]  len_q, len_d;
    logic [NB_IMAGE-1:0]  trip_q, trip_d;
    logic [NB_IMAGE-1:0]  idx_q, idx_d;
    logic [RCW-1:0]       run_q, run_d;
    logic [LCW-1:0]       lat_q, lat_d;
    logic [PW-1:0]        pix_q, pix_d;
    logic [RAM_WIDTH-1:0] res_q, res_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
`ifdef GPIO_SEQ_CHECKSUM_EN
    logic [RAM_WIDTH-1:0] sum_q, sum_d;
`endif

    logic [NB_IMAGE-1:0]  nres;
    logic                 last_res;
    logic [GPIO_D-1:0]    word;
    logic [RAM_WIDTH-1:0] pay;
    logic                 pix_ready;
    logic                 res_valid;
    logic                 res_last;
    logic                 unused_gpio;

    // Two edge columns of a row produce no result.
    assign nres = (len_q < NB_IMAGE'(3)) ? '0
                : len_q - NB_IMAGE'(2);
    assign last_res = (idx_q == nres - NB_IMAGE'(1));
    assign unused_gpio = ^bus.i_gpio_data[GPIO_D-1:RAM_WIDTH];

    always_ff @(posedge CLK100MHZ) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            trip_q  <= '0;
            idx_q   <= '0;
            run_q   <= '0;
            lat_q   <= '0;
            pix_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef GPIO_SEQ_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            trip_q  <= trip_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            lat_q   <= lat_d;
            pix_q   <= pix_d;
            res_q   <= res_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef GPIO_SEQ_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        trip_d  = trip_q;
        idx_d   = idx_q;
        run_d   = run_q;
        lat_d   = lat_q;
        pix_d   = pix_q;
        res_d   = res_q;
        err_d   = err_q;
        done_d  = 1'b0;
`ifdef GPIO_SEQ_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    len_d  = i_img_len;
                    err_d  = 1'b0;
                    trip_d = '0;
                    run_d  = '0;
                    idx_d  = '0;
                    if (i_img_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_INIT0;
                    end
                end
            end
            S_INIT0: state_d = S_INIT1;
            S_INIT1: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.i_pix_valid) begin
                    pix_d   = bus.i_pix_data;
                    state_d = S_W0;
                end
            end
            S_W0: state_d = S_W1;
            S_W1: state_d = S_W2;
            S_W2: begin
                trip_d = trip_q + NB_IMAGE'(1);
                if (trip_d == len_q) begin
                    run_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RUN: begin
                if (bus.i_eop) begin
                    idx_d = '0;
`ifdef GPIO_SEQ_CHECKSUM_EN
                    sum_d = '0;
`endif
                    if (nres != '0) begin
                        state_d = S_RREQ;
                    end else begin
`ifdef GPIO_SEQ_CHECKSUM_EN
                        res_d   = '0;
                        state_d = S_CSUM;
`else
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end
                end else if (run_q == RCW'(RUN_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    run_d = run_q + RCW'(1);
                end
            end
            S_RREQ: begin
                lat_d   = '0;
                state_d = S_RLAT;
            end
            S_RLAT: begin
                if (lat_q == LCW'(RD_LAT - 1)) begin
                    res_d   = bus.i_gpio_data[RAM_WIDTH-1:0];
                    state_d = S_ROUT;
                end else begin
                    lat_d = lat_q + LCW'(1);
                end
            end
            S_ROUT: begin
                if (bus.i_res_ready) begin
`ifdef GPIO_SEQ_CHECKSUM_EN
                    sum_d = sum_q + res_q;
`endif
                    if (!last_res) begin
                        idx_d   = idx_q + NB_IMAGE'(1);
                        state_d = S_RREQ;
                    end else begin
`ifdef GPIO_SEQ_CHECKSUM_EN
                        res_d   = sum_q + res_q;
                        state_d = S_CSUM;
`else
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            S_CSUM: begin
                if (bus.i_res_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word bits: 0 rst_conv, 1 k_i, 2 rst_fsm, 3 sop, 4 valid_fsm,
    // 6:5 sel, 7 load, payload above.
    always_comb begin
        word      = '0;
        pay       = '0;
        pix_ready = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            S_INIT0: begin
                word[0] = 1'b1;
                word[2] = 1'b1;
                pay     = RAM_WIDTH'(len_q);
            end
            S_WAIT: pix_ready = 1'b1;
            S_W0: begin
                word[7]   = 1'b1;
                word[6:5] = 2'b01;
                pay       = RAM_WIDTH'(pix_q[BIT_LEN-1:0]);
            end
            S_W1: begin
                word[7]   = 1'b1;
                word[6:5] = 2'b10;
                pay       = RAM_WIDTH'(pix_q[2*BIT_LEN-1:BIT_LEN]);
            end
            S_W2: begin
                word[7]   = 1'b1;
                word[6:5] = 2'b11;
                word[4]   = 1'b1;
                pay       = RAM_WIDTH'(pix_q[PW-1:2*BIT_LEN]);
            end
            S_RUN: begin
                if (!bus.i_eop) begin
                    word[1] = 1'b1;
                    word[4] = 1'b1;
                    word[3] = (run_q == '0);
                end
            end
            S_RREQ: word[4] = 1'b1;
            S_ROUT: res_valid = 1'b1;
            S_CSUM: res_valid = 1'b1;
            default: ;
        endcase
        word[RAM_WIDTH+7:8] = pay;
    end

`ifdef GPIO_SEQ_CHECKSUM_EN
    assign res_last = (state_q == S_CSUM);
`else
    assign res_last = (state_q == S_ROUT) && last_res;
`endif

    assign bus.o_gpio_data = word;
    assign bus.o_pix_ready = pix_ready;
    assign bus.o_res_data  = res_q;
    assign bus.o_res_valid = res_valid;
    assign bus.o_res_last  = res_last;
    assign o_busy  = (state_q != S_IDLE);
    assign o_done  = done_q;
    assign o_error = err_q;

endmodule

// File: tb/tb_gpio_host_sequencer.sv
// Randomised scoreboard bench for gpio_host_sequencer.
// Words and result beats are predicted from the control-word rules.
module tb_gpio_host_sequencer;

    localparam int TO = 32;
    localparam int RL = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] img_len;
    logic       busy;
    logic       done;
    logic       err;

    gpio_host_sequencer_if #(
        .GPIO_D(32), .RAM_WIDTH(13), .BIT_LEN(8)
    ) bus ();

    gpio_host_sequencer #(
        .GPIO_D(32), .RAM_WIDTH(13), .BIT_LEN(8),
        .NB_IMAGE(10), .RD_LAT(RL), .RUN_TIMEOUT(TO)
    ) dut (
        .CLK100MHZ(clk),
        .i_reset(rst),
        .i_start(start),
        .i_img_len(img_len),
        .bus(bus),
        .o_busy(busy),
        .o_done(done),
        .o_error(err)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] word_q[$];
    logic [13:0] res_q[$];
    logic [12:0] rd_q[$];
    logic [23:0] px_q[$];
    bit mon_en = 0;
    bit spacing = 0;
    bit rnd_rdy = 0;
    int stall_left = 0;
    int last_w0 = -1;
    int cyc = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s got=none exp=event", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected words and result beats.
    initial begin
        logic        hp;
        logic [14:0] hv;
        hp = 0;
        hv = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (bus.o_gpio_data != 0) begin
                    if (word_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL word_extra got=%h exp=none",
                                 bus.o_gpio_data);
                    end else begin
                        check("word", bus.o_gpio_data,
                              word_q.pop_front());
                    end
                    if (spacing && bus.o_gpio_data[7:0] == 8'hA0) begin
                        if (last_w0 >= 0)
                            check("triple_cycles", cyc - last_w0, 4);
                        last_w0 = cyc;
                    end
                end
                if (hp)
                    check("res_hold", {bus.o_res_valid,
                          bus.o_res_last, bus.o_res_data}, hv);
                hp = bus.o_res_valid && !bus.i_res_ready;
                hv = {bus.o_res_valid, bus.o_res_last, bus.o_res_data};
                if (bus.o_res_valid && bus.i_res_ready) begin
                    if (res_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL res_extra got=%h exp=none",
                                 bus.o_res_data);
                    end else begin
                        check("res", {bus.o_res_last, bus.o_res_data},
                              res_q.pop_front());
                    end
                end
            end
        end
    end

    // Result-ready driver.
    initial begin
        bus.i_res_ready = 0;
        forever begin
            tick();
            if (bus.o_res_valid && stall_left > 0) begin
                bus.i_res_ready = 0;
                stall_left--;
            end else begin
                bus.i_res_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // mem0 model: data appears RL cycles after a read pulse.
    initial begin
        int pend;
        logic [12:0] cur;
        logic [31:0] tmp;
        pend = 0;
        cur = '0;
        bus.i_gpio_data = '0;
        forever begin
            tick();
            tmp = $urandom;
            if (pend > 0) begin
                pend--;
                if (pend == 0) tmp[12:0] = cur;
            end
            bus.i_gpio_data = tmp;
            if (mon_en && bus.o_gpio_data == 32'h10) begin
                pend = RL;
                cur = (rd_q.size() > 0) ? rd_q.pop_front() : 13'h0;
            end
        end
    end

    task automatic start_job(input int len);
        start = 1;
        img_len = 10'(len);
        tick();
        start = 0;
    endtask

    task automatic feed(input bit rnd);
        int n;
        bit acc;
        for (int i = 0; i < px_q.size(); i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) tick();
            bus.i_pix_valid = 1;
            bus.i_pix_data = px_q[i];
            n = 0;
            acc = 0;
            while (!acc && n < 100) begin
                @(negedge clk);
                acc = bus.o_pix_ready;
                tick();
                n++;
            end
            if (!acc) fail_now("pix_accept_timeout");
            if (rnd) bus.i_pix_valid = 0;
        end
        bus.i_pix_valid = 0;
    endtask

    task automatic push_triples(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            word_q.push_back({16'h0, px_q[i][7:0], 8'hA0});
            word_q.push_back({16'h0, px_q[i][15:8], 8'hC0});
            word_q.push_back({16'h0, px_q[i][23:16], 8'hF0});
        end
    endtask

    // d = cycles from sop to i_eop; d = 0 lets the run time out.
    task automatic run_job(input int len, input int d,
                           input bit rnd, input bit fixed);
        int nres;
        int n;
        bit got;
        logic [12:0] v;
        logic [12:0] sum;
        if (len == 0) begin
            start_job(0);
            @(negedge clk);
            check("len0_done", done, 1);
            check("len0_busy", busy, 0);
            check("len0_err", err, 0);
            tick();
            @(negedge clk);
            check("len0_done_pulse", done, 0);
            tick();
            return;
        end
        nres = (len >= 3) ? len - 2 : 0;
        px_q.delete();
        for (int i = 0; i < len; i++)
            px_q.push_back(fixed ? 24'h030201 : 24'($urandom));
        word_q.push_back((32'(len) << 8) | 32'h5);
        push_triples(len);
        word_q.push_back(32'h1A);
        repeat ((d == 0 ? TO : d) - 1) word_q.push_back(32'h12);
        sum = '0;
        if (d != 0) begin
            for (int k = 0; k < nres; k++) begin
                if (fixed) v = (k == 0) ? 13'h0123 : 13'h1FFF;
                else v = 13'($urandom);
                rd_q.push_back(v);
                word_q.push_back(32'h10);
`ifdef GPIO_SEQ_CHECKSUM_EN
                res_q.push_back({1'b0, v});
`else
                res_q.push_back({k == nres - 1, v});
`endif
                sum = sum + v;
            end
`ifdef GPIO_SEQ_CHECKSUM_EN
            res_q.push_back({1'b1, sum});
`endif
        end
        spacing = !rnd;
        last_w0 = -1;
        start_job(len);
        @(negedge clk);
        check("err_clear", err, 0);
        check("busy_init", busy, 1);
        tick();
        feed(rnd);
        spacing = 0;
        n = 0;
        got = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = bus.o_gpio_data[3];
            if (!got) begin
                tick();
                n++;
            end
        end
        if (!got) fail_now("sop_timeout");
        if (d == 0) begin
            repeat (TO - 1) tick();
            @(negedge clk);
            check("to_err_before", err, 0);
            check("to_busy_before", busy, 1);
            tick();
            @(negedge clk);
            check("to_err", err, 1);
            check("to_busy", busy, 0);
            check("to_no_done", done, 0);
            tick();
            @(negedge clk);
            check("to_no_done2", done, 0);
            tick();
        end else begin
            for (int k = 1; k <= d; k++) begin
                tick();
                if (k == 1 && rnd && d >= 3) begin
                    start = 1;
                    img_len = 10'd7;
                end else begin
                    start = 0;
                end
            end
            start = 0;
            bus.i_eop = 1;
            tick();
            bus.i_eop = 0;
            n = 0;
            got = 0;
            while (!got && n < 1000) begin
                @(negedge clk);
                got = done;
                if (!got) n++;
            end
            check("done_seen", got, 1);
            check("busy_end", busy, 0);
            check("err_end", err, 0);
            tick();
        end
        check("wq_empty", word_q.size(), 0);
        check("rq_empty", res_q.size(), 0);
        check("rd_empty", rd_q.size(), 0);
    endtask

    task automatic reset_mid_load();
        px_q.delete();
        for (int i = 0; i < 2; i++) px_q.push_back(24'($urandom));
        word_q.push_back(32'h405);
        push_triples(1);
        word_q.push_back({16'h0, px_q[1][7:0], 8'hA0});
        word_q.push_back({16'h0, px_q[1][15:8], 8'hC0});
        start_job(4);
        feed(0);
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("rst_word", bus.o_gpio_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.o_pix_ready, 0);
        check("rst_valid", bus.o_res_valid, 0);
        check("rst_wq", word_q.size(), 0);
        tick();
    endtask

    initial begin
        rst = 1;
        start = 0;
        img_len = '0;
        bus.i_pix_valid = 0;
        bus.i_pix_data = '0;
        bus.i_eop = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_word", bus.o_gpio_data, 0);
        check("reset_busy", busy, 0);
        check("reset_valid", bus.o_res_valid, 0);
        check("reset_ready", bus.o_pix_ready, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        tick();
        rst = 0;
        mon_en = 1;
        tick();

        stall_left = 3;
        run_job(4, 20, 0, 1);
        run_job(3, 5, 0, 0);
        run_job(1, 4, 1, 0);
        run_job(2, 3, 1, 0);
        run_job(0, 0, 0, 0);
        run_job(2, 0, 0, 0);
        run_job(3, 6, 1, 0);
        reset_mid_load();
        run_job(4, 7, 0, 0);

        rnd_rdy = 1;
        for (int j = 0; j < 10; j++)
            run_job($urandom_range(0, 7), $urandom_range(1, 25), 1, 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
